mult_ctrl: RTL

- Control FSM for an N-bit sequential shift-add multiplier.
- Drives the load/clear strobes of the multiplicand, multiplier and product registers, plus the shift strobe of the multiplier/product shift path.
- Runs exactly N add/shift iterations per start request, then pulses done.
- Sits beside the datapath registers in the multiply top level; owns no data bits itself.

---
 rtl/mult_ctrl_pkg.sv | 15 +
 rtl/mult_ctrl_if.sv | 38 +++
 rtl/iter_counter.sv | 27 ++
 rtl/mult_ctrl.sv | 99 +++++++++
 4 files changed

// File: rtl/mult_ctrl_pkg.sv
// Shared types for the shift-add multiplier controller.
package mult_ctrl_pkg;

    localparam int unsigned NumStates = 5;
    localparam int unsigned StateW    = $clog2(NumStates);

    typedef enum logic [StateW-1:0] {
        StIdle  = 3'd0,
        StInit  = 3'd1,
        StAdd   = 3'd2,
        StShift = 3'd3,
        StDone  = 3'd4
    } state_t;

endpackage

// File: rtl/mult_ctrl_if.sv
// Strobe/feedback bundle between the multiplier controller (master) and its datapath (slave).
interface mult_ctrl_if;

    logic start;
    logic b_lsb;
    logic ld_a;
    logic ld_b;
    logic clr_p;
    logic ld_p;
    logic shift;
    logic busy;
    logic done;

    modport master (
        input  start,
        input  b_lsb,
        output ld_a,
        output ld_b,
        output clr_p,
        output ld_p,
        output shift,
        output busy,
        output done
    );

    modport slave (
        output start,
        output b_lsb,
        input  ld_a,
        input  ld_b,
        input  clr_p,
        input  ld_p,
        input  shift,
        input  busy,
        input  done
    );

endinterface

// File: rtl/iter_counter.sv
// Iteration counter for the multiplier controller; flags the final iteration.
module iter_counter #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          init,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          last
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (clear || init) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign count = r_count;
    assign last  = (r_count == CW'(N - 1));

endmodule

// File: rtl/mult_ctrl.sv
// Control FSM for an N-bit sequential shift-add multiplier: INIT, N x (ADD, SHIFT), DONE.
module mult_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic       clk,
    input  logic       clear,
    mult_ctrl_if.master bus
);

    localparam int unsigned CW = $clog2(N);

    state_t        r_state;
    logic          r_init;
    logic          r_shift;
    logic          r_busy;
    logic          r_done;
    logic          w_init;
    logic          w_inc;
    logic          w_last;
    logic [CW-1:0] w_count;

    assign w_init = (r_state == StInit);
    assign w_inc  = (r_state == StShift) && !w_last;

    iter_counter #(
        .N  (N),
        .CW (CW)
    ) u_iter_counter (
        .clk   (clk),
        .clear (clear),
        .init  (w_init),
        .inc   (w_inc),
        .count (w_count),
        .last  (w_last)
    );

    // Moore outputs are registered alongside the state so they line up with it.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= StIdle;
            r_init  <= 1'b0;
            r_shift <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_init  <= 1'b0;
            r_shift <= 1'b0;
            r_done  <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_state <= StInit;
                        r_init  <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                StInit: r_state <= StAdd;
                StAdd: begin
                    r_state <= StShift;
                    r_shift <= 1'b1;
                end
                StShift: begin
                    if (w_last) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= StAdd;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ld_a  = r_init;
    assign bus.ld_b  = r_init;
    assign bus.clr_p = r_init;
    assign bus.ld_p  = (r_state == StAdd) & bus.b_lsb;
    assign bus.shift = r_shift;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;

    // DONE is only reachable once the counter has reached its final value.
    always_ff @(posedge clk) begin
        if (!clear && r_state == StDone) begin
            assert (w_count == CW'(N - 1));
        end
    end

endmodule
